// File: rtl/rat.sv
// Register alias table: maps each architectural GPR to the ROB entry
// producing its newest value; cleared on commit, flushed on redirect.
module rat #(
  parameter int GPR_NUM        = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int ROB_DEPTH      = 32,
  parameter int TAG_WIDTH      = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      alloc_en,
  input  logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
  input  logic                      alloc_dst_wen,
  input  logic                      commit_en,
  input  logic [GPR_ADDR_WIDTH-1:0] commit_dst_addr,
  input  logic [TAG_WIDTH-1:0]      commit_Paddr,
  input  logic                      commit_br_taken,
  input  logic                      commit_exp_en,
  output logic                      rs1_rat_valid,
  output logic [TAG_WIDTH-1:0]      rs1_Paddr,
  output logic                      rs2_rat_valid,
  output logic [TAG_WIDTH-1:0]      rs2_Paddr,
  output logic [GPR_ADDR_WIDTH:0]   mapped_cnt
);

  localparam int CW = GPR_ADDR_WIDTH + 1;

  logic [GPR_NUM-1:0]                valid_q, valid_d;
  logic [GPR_NUM-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CW-1:0]                     cnt_q, cnt_d;

  logic flush;
  logic alloc_hit;
  logic commit_hit;
  logic same_dst;
  logic inc;
  logic dec;

  assign flush = commit_en &&
                 (commit_br_taken || commit_exp_en);

  assign alloc_hit = alloc_en && alloc_dst_wen &&
                     (alloc_dst_addr != '0);

  assign commit_hit = commit_en &&
                      (commit_dst_addr != '0) &&
                      valid_q[commit_dst_addr] &&
                      (tag_q[commit_dst_addr] == commit_Paddr);

  assign same_dst = (alloc_dst_addr == commit_dst_addr);

  // A commit on the same register as a new allocate is overridden,
  // so it must not decrement the count either.
  assign inc = alloc_hit && !valid_q[alloc_dst_addr];
  assign dec = commit_hit && !(alloc_hit && same_dst);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = '0;
      cnt_d   = '0;
    end else begin
      if (commit_hit)
        valid_d[commit_dst_addr] = 1'b0;
      if (alloc_hit) begin
        valid_d[alloc_dst_addr] = 1'b1;
        tag_d[alloc_dst_addr]   = alloc_tag;
      end
      unique case (1'b1)
        (inc && !dec): cnt_d = cnt_q + CW'(1);
        (dec && !inc): cnt_d = cnt_q - CW'(1);
        default:       cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rs1_rat_valid = (rs1_addr != '0) && valid_q[rs1_addr];
  assign rs2_rat_valid = (rs2_addr != '0) && valid_q[rs2_addr];
  assign rs1_Paddr = (rs1_addr != '0) ? tag_q[rs1_addr] : '0;
  assign rs2_Paddr = (rs2_addr != '0) ? tag_q[rs2_addr] : '0;
  assign mapped_cnt = cnt_q;

endmodule

// File: tb/tb_rat.sv
// Bench for rat: directed scenarios plus random traffic checked
// against an array-based model of the alias table.
module tb_rat;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr, rs2_addr;
  logic       alloc_en;
  logic [4:0] alloc_tag;
  logic [4:0] alloc_dst_addr;
  logic       alloc_dst_wen;
  logic       commit_en;
  logic [4:0] commit_dst_addr;
  logic [4:0] commit_Paddr;
  logic       commit_br_taken;
  logic       commit_exp_en;
  logic       rs1_rat_valid, rs2_rat_valid;
  logic [4:0] rs1_Paddr, rs2_Paddr;
  logic [5:0] mapped_cnt;

  int checks = 0;
  int errors = 0;

  bit       m_valid [32];
  bit [4:0] m_tag   [32];

  always #5 clk = ~clk;

  rat dut (
    .clk(clk),
    .rst(rst),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .alloc_en(alloc_en),
    .alloc_tag(alloc_tag),
    .alloc_dst_addr(alloc_dst_addr),
    .alloc_dst_wen(alloc_dst_wen),
    .commit_en(commit_en),
    .commit_dst_addr(commit_dst_addr),
    .commit_Paddr(commit_Paddr),
    .commit_br_taken(commit_br_taken),
    .commit_exp_en(commit_exp_en),
    .rs1_rat_valid(rs1_rat_valid),
    .rs1_Paddr(rs1_Paddr),
    .rs2_rat_valid(rs2_rat_valid),
    .rs2_Paddr(rs2_Paddr),
    .mapped_cnt(mapped_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_valid[r]);
    return n;
  endfunction

  function automatic int m_lv(input logic [4:0] a);
    return (a == 0) ? 0 : int'(m_valid[a]);
  endfunction

  function automatic int m_lt(input logic [4:0] a);
    return (a == 0) ? 0 : int'(m_tag[a]);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_valid[r] = 0;
      m_tag[r]   = '0;
    end
  endtask

  // Apply one clock edge of architectural behaviour to the model.
  task automatic m_update();
    bit fl;
    bit hit;
    fl = commit_en && (commit_br_taken || commit_exp_en);
    if (fl) begin
      for (int r = 0; r < 32; r++) m_valid[r] = 0;
    end else begin
      hit = commit_en && commit_dst_addr != 0 &&
            m_valid[commit_dst_addr] &&
            m_tag[commit_dst_addr] == commit_Paddr;
      if (hit) m_valid[commit_dst_addr] = 0;
      if (alloc_en && alloc_dst_wen && alloc_dst_addr != 0) begin
        m_valid[alloc_dst_addr] = 1;
        m_tag[alloc_dst_addr]   = alloc_tag;
      end
    end
  endtask

  task automatic drv(
    input logic [4:0] r1, input logic [4:0] r2,
    input logic ae, input logic [4:0] ad, input logic [4:0] at,
    input logic ce, input logic [4:0] cd, input logic [4:0] cp,
    input logic br, input logic ex
  );
    rs1_addr        = r1;
    rs2_addr        = r2;
    alloc_en        = ae;
    alloc_dst_addr  = ad;
    alloc_tag       = at;
    alloc_dst_wen   = 1'b1;
    commit_en       = ce;
    commit_dst_addr = cd;
    commit_Paddr    = cp;
    commit_br_taken = br;
    commit_exp_en   = ex;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drv(r1, r2, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    #1;
    chk("rs1_valid", rs1_rat_valid, m_lv(rs1_addr));
    chk("rs1_paddr", rs1_Paddr, m_lt(rs1_addr));
    chk("rs2_valid", rs2_rat_valid, m_lv(rs2_addr));
    chk("rs2_paddr", rs2_Paddr, m_lt(rs2_addr));
    chk("cnt", mapped_cnt, m_count());
    @(posedge clk);
    m_update();
    #1;
  endtask

  initial begin
    logic [4:0] a;
    rst = 1'b1;
    m_reset();
    idle(5, 0);
    #12;
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_rs1_v", rs1_rat_valid, 0);
    chk("rst_rs2_v", rs2_rat_valid, 0);
    chk("rst_rs1_p", rs1_Paddr, 0);
    chk("rst_cnt", mapped_cnt, 0);
    tick();

    // Allocate x5 -> 3; not visible in its own cycle
    drv(5, 0, 1, 5, 3, 0, 0, 0, 0, 0);
    #1;
    chk("same_cyc_v", rs1_rat_valid, 0);
    tick();
    idle(5, 0);
    #1;
    chk("x5_v", rs1_rat_valid, 1);
    chk("x5_p", rs1_Paddr, 3);
    chk("x5_cnt", mapped_cnt, 1);

    // Remap x5 -> 7, then commits of stale and current tags
    drv(5, 0, 1, 5, 7, 0, 0, 0, 0, 0);
    tick();
    drv(5, 0, 0, 0, 0, 1, 5, 3, 0, 0);
    tick();
    idle(5, 0);
    #1;
    chk("stale_v", rs1_rat_valid, 1);
    chk("stale_p", rs1_Paddr, 7);
    drv(5, 0, 0, 0, 0, 1, 5, 7, 0, 0);
    #1;
    chk("commit_cyc_v", rs1_rat_valid, 1);
    tick();
    idle(5, 0);
    #1;
    chk("clr_v", rs1_rat_valid, 0);
    chk("clr_cnt", mapped_cnt, 0);

    // Same-cycle allocate and commit on x6: allocate wins
    drv(6, 0, 1, 6, 4, 0, 0, 0, 0, 0);
    tick();
    drv(6, 0, 1, 6, 9, 1, 6, 4, 0, 0);
    tick();
    idle(6, 0);
    #1;
    chk("x6_v", rs1_rat_valid, 1);
    chk("x6_p", rs1_Paddr, 9);
    chk("x6_cnt", mapped_cnt, 1);

    // Flush by taken branch, then by exception
    for (int k = 0; k < 2; k++) begin
      for (int r = 1; r <= 3; r++) begin
        drv(5'(r), 6, 1, 5'(r), 5'(10 + r), 0, 0, 0, 0, 0);
        tick();
      end
      drv(4, 1, 1, 4, 20, 1, 9, 2, k == 0, k == 1);
      tick();
      idle(4, 1);
      #1;
      chk("fl_x4_v", rs1_rat_valid, 0);
      chk("fl_x1_v", rs2_rat_valid, 0);
      chk("fl_cnt", mapped_cnt, 0);
    end

    // Allocate to x0 is ignored
    drv(0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    tick();
    idle(0, 0);
    #1;
    chk("x0_v", rs1_rat_valid, 0);
    chk("x0_p", rs1_Paddr, 0);
    chk("x0_cnt", mapped_cnt, 0);

    // Asynchronous reset mid-sequence
    drv(7, 8, 1, 7, 2, 0, 0, 0, 0, 0);
    tick();
    drv(7, 8, 1, 8, 6, 0, 0, 0, 0, 0);
    tick();
    idle(7, 8);
    #1;
    chk("pre_rst_cnt", mapped_cnt, 2);
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_rs1_v", rs1_rat_valid, 0);
    chk("arst_rs2_v", rs2_rat_valid, 0);
    chk("arst_rs2_p", rs2_Paddr, 0);
    chk("arst_cnt", mapped_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      a = 5'($urandom_range(0, 31));
      drv(5'($urandom), 5'($urandom),
          ($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
          ($urandom_range(0, 1) == 1),
          5'($urandom), 5'($urandom),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 24) == 0));
      alloc_dst_wen = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1 && m_valid[a]) begin
        commit_dst_addr = a;
        commit_Paddr    = m_tag[a];
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat.md
Name: rat

Overview:
- Register alias table: maps each architectural GPR to the ROB entry that will produce its newest value.
- Sits between the decoder/rename stage and the ROB.
- Consumes the ROB's allocate interface (tag, dst addr, wen) and commit interface (commit_en, Aaddr, Paddr, branch-taken, exception).
- Produces the per-source rename lookup (rs*_rat_valid, rs*_Paddr) that the ROB uses to forward operands.

Parameters:
- GPR_NUM, 32, number of architectural registers.
- GPR_ADDR_WIDTH, 5, architectural register address width.
- ROB_DEPTH, 32, ROB entries.
- TAG_WIDTH, $clog2(ROB_DEPTH), ROB tag (Paddr) width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; asynchronous, active-high
- rs1_addr  in  GPR_ADDR_WIDTH  source 1 architectural address from decoder
- rs2_addr  in  GPR_ADDR_WIDTH  source 2 architectural address from decoder
- alloc_en  in  1  rename/allocate fires this cycle (same as ROB allocate_en)
- alloc_tag  in  TAG_WIDTH  ROB entry being allocated
- alloc_dst_addr  in  GPR_ADDR_WIDTH  destination Aaddr
- alloc_dst_wen  in  1  instruction writes a GPR
- commit_en  in  1  ROB head retires this cycle
- commit_dst_addr  in  GPR_ADDR_WIDTH  retiring Aaddr
- commit_Paddr  in  TAG_WIDTH  retiring ROB tag
- commit_br_taken  in  1  retiring branch redirects
- commit_exp_en  in  1  retiring instruction raised an exception
- rs1_rat_valid  out  1  rs1 is renamed; value comes from the ROB
- rs1_Paddr  out  TAG_WIDTH  ROB tag for rs1
- rs2_rat_valid  out  1  rs2 is renamed
- rs2_Paddr  out  TAG_WIDTH  ROB tag for rs2
- mapped_cnt  out  GPR_ADDR_WIDTH+1  number of currently valid mappings (registered)

Behaviour:
- State per register r: valid[r] (1 bit) and tag[r] (TAG_WIDTH).
- Reset (rst high, asynchronous): all valid=0, all tag=0, mapped_cnt=0. Lookup outputs are therefore valid=0, Paddr=0.
- Lookup is combinational from current state:
  - rsN_rat_valid = valid[rsN_addr]; rsN_Paddr = tag[rsN_addr].
  - No bypass of this cycle's allocate: an instruction's own destination never maps its own sources.
  - No bypass of this cycle's commit clear: the ROB entry stays readable during its commit cycle.
  - rsN_addr==0 always gives valid=0, Paddr=0.
- Flush:
  - flush = commit_en && (commit_br_taken || commit_exp_en).
  - On flush, next state is all valid=0. Tags are untouched.
  - A same-cycle allocate is discarded, since the younger instruction is squashed.
  - mapped_cnt becomes 0.
- Allocate (no flush):
  - Condition: alloc_en && alloc_dst_wen && alloc_dst_addr!=0.
  - Effect: valid[alloc_dst_addr]<=1, tag[alloc_dst_addr]<=alloc_tag. This overwrites any older mapping.
- Commit clear (no flush):
  - Condition: commit_en && valid[commit_dst_addr] && tag[commit_dst_addr]==commit_Paddr && commit_dst_addr!=0.
  - Effect: valid[commit_dst_addr]<=0.
  - If the tag mismatches, a younger producer owns the register and the entry is kept.
- Simultaneous allocate and commit to the same Aaddr: allocate wins (valid=1, new tag).
- Allocate and commit to different Aaddrs in the same cycle: both take effect.
- mapped_cnt is a registered count:
  - +1 when allocate sets a previously invalid entry.
  - −1 when commit clears an entry.
  - Net 0 when both hit the same Aaddr.
  - Range 0..GPR_NUM-1, because x0 is never mapped.
- Latency: mapping updates are visible to lookups the cycle after the update edge.

Test Plan:
- Reset, then lookup rs1=5, rs2=0 -> rs1_rat_valid=0, rs2_rat_valid=0, Paddrs=0, mapped_cnt=0.
- Allocate dst=5 tag=3; next cycle lookup rs1=5 -> valid=1, Paddr=3, mapped_cnt=1. Same-cycle lookup of rs1=5 during the allocate -> valid=0.
- Remap ordering:
  - Allocate x5->tag3, then x5->tag7.
  - Commit (x5, Paddr 3) -> x5 stays valid, tag 7.
  - Commit (x5, Paddr 7) -> valid=0, mapped_cnt=0.
- Same-cycle allocate x6->tag9 with commit (x6, Paddr 4, tag matches) -> x6 valid, tag 9, mapped_cnt unchanged.
- Map x1,x2,x3; commit with commit_br_taken=1 while alloc_en maps x4 -> all valid=0, x4 not mapped, mapped_cnt=0. Repeat the flush with commit_exp_en=1 -> same result.
- Allocate dst=0 with wen=1 -> no mapping, mapped_cnt=0. Assert rst mid-sequence -> all outputs 0 immediately, before the next clk edge.
